// File: rtl/multi_servo_pwm.sv
// multi_servo_pwm
//   Drives N_CH servo channels from one shared frame counter. Each channel
//   flips between two preset pulse widths (closed / open) on a one-cycle
//   request that is accepted only while the mode gate is high. The active
//   pulse width changes only at a frame boundary, so a pulse in flight is
//   never cut short or stretched.
//
//   Optional feature macro: SERVO_SLEW_EN
//     defined   - width walks toward its target by at most STEP_CYC per frame
//     undefined - width jumps straight to its target at the next boundary
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       mode gate; toggle requests are ignored while low
//   toggle       [N_CH]   one-cycle requests, bit i flips channel i's target
//   pwm          [N_CH]   registered servo outputs
//   pos_state    [N_CH]   current target per channel (1 = open, 0 = closed)
//   history      [2*N_CH] {previous, current} target per channel, bits [2i+1:2i]
//   moving       [N_CH]   high while a channel's width differs from its target
//   frame_start           one-cycle pulse on the first pwm cycle of each frame
module multi_servo_pwm #(
    parameter int N_CH       = 2,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int CNT_W      = 20,
    parameter int CLOSE_HIGH = 170_000,
    parameter int OPEN_HIGH  = 75_000,
    parameter int STEP_CYC   = 5_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_CH-1:0]     toggle,
    output logic [N_CH-1:0]     pwm,
    output logic [N_CH-1:0]     pos_state,
    output logic [2*N_CH-1:0]   history,
    output logic [N_CH-1:0]     moving,
    output logic                frame_start
);

    // Parameter sanity, rejected at elaboration.
    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $error("multi_servo_pwm: N_CH must be 1..8");
    end
    if (!(CLOSE_HIGH > 0 && CLOSE_HIGH < PERIOD_CYC &&
          OPEN_HIGH > 0 && OPEN_HIGH < PERIOD_CYC)) begin : g_bad_width
        $error("multi_servo_pwm: pulse widths must lie in 1..PERIOD_CYC-1");
    end
    if (STEP_CYC <= 0) begin : g_bad_step
        $error("multi_servo_pwm: STEP_CYC must be positive");
    end
    if ((64'd1 << CNT_W) <= 64'(PERIOD_CYC)) begin : g_bad_cntw
        $error("multi_servo_pwm: CNT_W too narrow for PERIOD_CYC");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] CLOSE_W  = CNT_W'(CLOSE_HIGH);
    localparam logic [CNT_W-1:0] OPEN_W   = CNT_W'(OPEN_HIGH);

`ifdef SERVO_SLEW_EN
    localparam logic [CNT_W-1:0]        STEP_W = CNT_W'(STEP_CYC);
    localparam logic signed [CNT_W:0]   STEP_S = (CNT_W+1)'(STEP_CYC);

    // One frame's worth of motion from cur toward tgt. The difference is
    // taken one bit wider and signed so neither direction can wrap; when the
    // remaining distance is within one step we land exactly on the target.
    function automatic logic [CNT_W-1:0] slew_next(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            slew_next = cur + STEP_W;
        else if (diff < -STEP_S)
            slew_next = cur - STEP_W;
        else
            slew_next = tgt;
    endfunction
`endif

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]    pwm_q, pwm_d;
    logic [N_CH-1:0]    pos_q, pos_d;
    logic [2*N_CH-1:0]  hist_q, hist_d;
    logic [N_CH-1:0]    moving_q, moving_d;
    logic               frame_start_q, frame_start_d;
    logic [CNT_W-1:0]   cur_high_q [N_CH];
    logic [CNT_W-1:0]   cur_high_d [N_CH];
    logic [CNT_W-1:0]   tgt        [N_CH];
    logic               boundary;

    always_comb begin
        boundary      = (cnt_q == LAST_CNT);
        cnt_d         = boundary ? '0 : cnt_q + CNT_W'(1);
        frame_start_d = (cnt_q == '0);
        pos_d         = pos_q;
        hist_d        = hist_q;
        pwm_d         = '0;
        moving_d      = '0;
        for (int i = 0; i < N_CH; i++) begin
            tgt[i]        = pos_q[i] ? OPEN_W : CLOSE_W;
            cur_high_d[i] = cur_high_q[i];
            pwm_d[i]      = (cnt_q < cur_high_q[i]);
            moving_d[i]   = (cur_high_q[i] != tgt[i]);
            if (enable && toggle[i]) begin
                pos_d[i]      = ~pos_q[i];
                hist_d[2*i+1] = hist_q[2*i];
                hist_d[2*i]   = ~hist_q[2*i];
            end
            // Width only changes on the last cycle of a frame.
            if (boundary) begin
`ifdef SERVO_SLEW_EN
                cur_high_d[i] = slew_next(cur_high_q[i], tgt[i]);
`else
                cur_high_d[i] = tgt[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            pwm_q         <= '0;
            pos_q         <= '0;
            hist_q        <= '0;
            moving_q      <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) cur_high_q[i] <= CLOSE_W;
        end else begin
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            pos_q         <= pos_d;
            hist_q        <= hist_d;
            moving_q      <= moving_d;
            frame_start_q <= frame_start_d;
            for (int i = 0; i < N_CH; i++) cur_high_q[i] <= cur_high_d[i];
        end
    end

    assign pwm         = pwm_q;
    assign pos_state   = pos_q;
    assign history     = hist_q;
    assign moving      = moving_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_multi_servo_pwm.sv
module tb_multi_servo_pwm;

    localparam int PER = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] toggle = 2'b00;
    logic [1:0] pwm, pos_state, moving;
    logic [3:0] history;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    multi_servo_pwm #(
        .N_CH(2), .PERIOD_CYC(PER), .CNT_W(7),
        .CLOSE_HIGH(60), .OPEN_HIGH(30), .STEP_CYC(10)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .toggle(toggle),
        .pwm(pwm), .pos_state(pos_state), .history(history),
        .moving(moving), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] tog;
        logic [1:0] exp_pos;
        logic [3:0] exp_hist;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (!frame_start && n < 250) begin
            tick();
            n++;
        end
        if (!frame_start) begin
            tests++;
            fails++;
            $display("FAIL wait_frame_start: got timeout, expected pulse within 250 cycles");
        end
    endtask

    // Observe one whole frame starting at the frame_start sample. Sample k sees
    // the pwm value produced from counter value k. Optionally drive a request
    // right after sample inj_k, so the DUT samples it with counter = inj_k+1.
    task automatic measure(input int inj_k, input logic inj_en, input logic [1:0] inj_tog,
                           output int w0, output int w1, output int m0, output int m1,
                           output int fs);
        wait_fs();
        w0 = 0; w1 = 0; m0 = 0; m1 = 0; fs = 0;
        for (int k = 0; k < PER; k++) begin
            w0 += int'(pwm[0]);
            w1 += int'(pwm[1]);
            m0 += int'(moving[0]);
            m1 += int'(moving[1]);
            fs += int'(frame_start);
            if (k == inj_k) begin
                enable = inj_en;
                toggle = inj_tog;
            end else begin
                toggle = 2'b00;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int w0, w1, m0, m1, fs;
    int exp_w0 [3];
    int exp_m0 [3];
    int exp_w1 [4];

    initial begin
        vecs[0] = '{en: 1'b0, tog: 2'b11, exp_pos: 2'b00, exp_hist: 4'b0000};
        vecs[1] = '{en: 1'b1, tog: 2'b01, exp_pos: 2'b01, exp_hist: 4'b0001};
        vecs[2] = '{en: 1'b1, tog: 2'b10, exp_pos: 2'b11, exp_hist: 4'b0101};
        vecs[3] = '{en: 1'b1, tog: 2'b11, exp_pos: 2'b00, exp_hist: 4'b1010};
        vecs[4] = '{en: 1'b0, tog: 2'b01, exp_pos: 2'b00, exp_hist: 4'b1010};
        vecs[5] = '{en: 1'b1, tog: 2'b01, exp_pos: 2'b01, exp_hist: 4'b1001};
        vecs[6] = '{en: 1'b1, tog: 2'b00, exp_pos: 2'b01, exp_hist: 4'b1001};
`ifdef SERVO_SLEW_EN
        exp_w0 = '{50, 40, 30};
        exp_m0 = '{100, 100, 0};
        exp_w1 = '{50, 40, 50, 60};
`else
        exp_w0 = '{30, 30, 30};
        exp_m0 = '{0, 0, 0};
        exp_w1 = '{30, 30, 60, 60};
`endif

        // Reset state
        #3;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_pos", int'(pos_state), 0);
        chk("rst_hist", int'(history), 0);
        chk("rst_moving", int'(moving), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("first_frame_start", int'(frame_start), 1);

        // Idle frame: both channels closed
        measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
        chk("idle_w0", w0, 60);
        chk("idle_w1", w1, 60);
        chk("idle_fs", fs, 1);
        chk("idle_moving", m0 + m1, 0);

        // Requests while the mode gate is low are ignored
        measure(39, 1'b0, 2'b11, w0, w1, m0, m1, fs);
        chk("gated_pos", int'(pos_state), 0);
        chk("gated_hist", int'(history), 0);
        measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
        chk("gated_w0", w0, 60);
        chk("gated_w1", w1, 60);

        // Open channel 0 mid-frame: current frame keeps its pulse
        measure(39, 1'b1, 2'b01, w0, w1, m0, m1, fs);
        chk("open0_cur_w0", w0, 60);
        chk("open0_cur_m0", m0, 59);
        chk("open0_pos", int'(pos_state), 1);
        chk("open0_hist", int'(history), 1);
        for (int f = 0; f < 3; f++) begin
            measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
            chk($sformatf("open0_f%0d_w0", f + 1), w0, exp_w0[f]);
            chk($sformatf("open0_f%0d_m0", f + 1), m0, exp_m0[f]);
            chk($sformatf("open0_f%0d_w1", f + 1), w1, 60);
        end

        // Channel 1 opened, then reversed two frames later
        do_reset();
        measure(39, 1'b1, 2'b10, w0, w1, m0, m1, fs);
        chk("rev_f0_w1", w1, 60);
        chk("rev_hist_a", int'(history[3:2]), 1);
        measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
        chk("rev_f1_w1", w1, exp_w1[0]);
        measure(39, 1'b1, 2'b10, w0, w1, m0, m1, fs);
        chk("rev_f2_w1", w1, exp_w1[1]);
        chk("rev_hist_b", int'(history[3:2]), 2);
        measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
        chk("rev_f3_w1", w1, exp_w1[2]);
        measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
        chk("rev_f4_w1", w1, exp_w1[3]);
        chk("rev_f4_w0", w0, 60);

        // Table of single-cycle request vectors
        do_reset();
        for (int v = 0; v < 7; v++) begin
            enable = vecs[v].en;
            toggle = vecs[v].tog;
            tick();
            toggle = 2'b00;
            chk($sformatf("vec%0d_pos", v), int'(pos_state), int'(vecs[v].exp_pos));
            chk($sformatf("vec%0d_hist", v), int'(history), int'(vecs[v].exp_hist));
        end

        // Simultaneous toggle, then reset in the middle of a pulse
        do_reset();
        wait_fs();
        enable = 1'b1;
        toggle = 2'b11;
        tick();
        toggle = 2'b00;
        chk("both_pos", int'(pos_state), 3);
        chk("both_hist", int'(history), 5);
        for (int k = 1; k < 19; k++) tick();
        chk("midpulse_pwm", int'(pwm), 3);
        chk("midpulse_moving", int'(moving), 3);
        #2 reset = 1'b1;
        #1;
        chk("async_pwm", int'(pwm), 0);
        chk("async_pos", int'(pos_state), 0);
        chk("async_hist", int'(history), 0);
        chk("async_moving", int'(moving), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("restart_frame_start", int'(frame_start), 1);
        measure(-1, 1'b0, 2'b00, w0, w1, m0, m1, fs);
        chk("restart_w0", w0, 60);
        chk("restart_w1", w1, 60);
        chk("restart_pos", int'(pos_state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
